// File: rtl/pipe_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage integer core.
// Drives the PC, IF/ID and ID/EX stall/flush controls for load-use bubbles,
// taken branches resolved in EX, and fixed-latency multi-cycle EX ops.
// Optional build macro PIPE_PERF_CNT_EN adds stall-cycle and flush counters.
module pipe_ctrl #(
  parameter int MC_LAT = 32,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_reg1addr,
  input  logic       id_reg1en,
  input  logic [4:0] id_reg2addr,
  input  logic       id_reg2en,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwe,
  input  logic       ex_is_load,
  input  logic       ex_mc_start,
  input  logic       ex_br_taken,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       stall_id_ex,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       mc_busy,
`ifdef PIPE_PERF_CNT_EN
  output logic       mc_done,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
`else
  output logic       mc_done
`endif
);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] mc_cnt, mc_cnt_nxt;
  logic             hz1, hz2, lu;

  // Load-use match against the EX destination; x0 never creates a hazard.
  always_comb begin
    hz1 = ex_is_load & ex_regwe & id_reg1en & (id_reg1addr == ex_rd) & (ex_rd != 5'd0);
    hz2 = ex_is_load & ex_regwe & id_reg2en & (id_reg2addr == ex_rd) & (ex_rd != 5'd0);
    lu  = hz1 | hz2;
  end

  // State and multi-cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
    end
  end

  // Next state and same-cycle controls; branch beats multi-cycle beats load-use.
  always_comb begin
    state_nxt   = state;
    mc_cnt_nxt  = mc_cnt;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    stall_id_ex = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    mc_busy     = 1'b0;
    mc_done     = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (ex_br_taken) begin
            // A concurrent ex_mc_start is illegal and dropped here.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (ex_mc_start) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
            mc_busy     = 1'b1;
            state_nxt   = MC_WAIT;
            // Issue cycle counts toward MC_LAT; WAIT runs MC_LAT-1 cycles.
            mc_cnt_nxt  = CNT_W'(MC_LAT - 2);
          end else if (lu) begin
            // One bubble: the load reaches MEM next cycle and forwarding takes over.
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
        MC_WAIT: begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
          mc_busy     = 1'b1;
          if (mc_cnt == '0) begin
            mc_done   = 1'b1;
            state_nxt = RUN;
          end else begin
            mc_cnt_nxt = mc_cnt - 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Free-running performance counters; wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_pc)    perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (flush_if_id) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
